// File: rtl/bucket_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bucket_issue_ctrl_pkg
// Shared definitions for the bucket issue controller:
//   - 96-bit element layout {hash[95:64], id[63:32], freq[31:0]}
//   - bucket index extraction from the hash field
//   - drain FSM state encoding
// -----------------------------------------------------------------------------
package bucket_issue_ctrl_pkg;

  localparam int ELEM_W   = 96;

  localparam int HASH_LSB = 64;
  localparam int HASH_MSB = 95;
  localparam int ID_LSB   = 32;
  localparam int ID_MSB   = 63;
  localparam int FREQ_LSB = 0;
  localparam int FREQ_MSB = 31;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Hash field shifted down by 'base'. The caller truncates the result to
  // its own index width, so this stays independent of RAM_PTR.
  function automatic logic [31:0] bucket_idx(input elem_t e, input int base);
    logic [31:0] h;
    h = e[HASH_MSB:HASH_LSB];
    return h >> base;
  endfunction

endpackage

// File: rtl/bucket_haz_window.sv
// -----------------------------------------------------------------------------
// bucket_haz_window
// Shift register of the last HAZ_DEPTH issue slots ({v, idx} per slot) with a
// parallel comparator for two query indices.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_v, in_idx   slot being issued this cycle (becomes entry 0 next cycle,
//                  which therefore mirrors the output register)
//   q0_idx, q1_idx query indices (one per requester)
//   q0_conflict    q0_idx matches a valid entry
//   q1_conflict    q1_idx matches a valid entry
//   empty          no entry holds a valid slot
// -----------------------------------------------------------------------------
module bucket_haz_window #(
  parameter int RAM_PTR   = 10,
  parameter int HAZ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_v,
  input  logic [RAM_PTR-1:0] in_idx,
  input  logic [RAM_PTR-1:0] q0_idx,
  input  logic [RAM_PTR-1:0] q1_idx,
  output logic               q0_conflict,
  output logic               q1_conflict,
  output logic               empty
);

  typedef struct packed {
    logic               v;
    logic [RAM_PTR-1:0] idx;
  } entry_t;

  entry_t win [HAZ_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        win[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage read the pre-edge
      // value of its neighbour, which is what turns this into a shift register.
      win[0] <= '{v: in_v, idx: in_idx};
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        win[i] <= win[i-1];
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    q0_conflict = 1'b0;
    q1_conflict = 1'b0;
    empty       = 1'b1;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (win[i].v) begin
        empty = 1'b0;
        if (win[i].idx == q0_idx) q0_conflict = 1'b1;
        if (win[i].idx == q1_idx) q1_conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bucket_issue_ctrl.sv
// -----------------------------------------------------------------------------
// bucket_issue_ctrl
// Admission controller / arbiter in front of one part_1 bucket stage. Merges
// new elements (req0) and re-entering evicted elements (req1), issues at most
// one element per cycle, and holds back any element whose bucket index is
// still inside the read-modify-write window of the bucket RAM.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_hash_e_f/valid/ready new element stream (ready = granted this cycle)
//   req1_hash_e_f/valid/ready re-entering element stream
//   hash_e_f, valid           registered one-cycle issue pulse to part_1
//   drain_req                 level: stop admission and empty the pipeline
//   drain_done                high while the stage is drained
//   issue_cnt                 saturating count of issued elements
//   stall_cnt                 saturating count of cycles with a valid but
//                             ungranted requester
// -----------------------------------------------------------------------------
module bucket_issue_ctrl
  import bucket_issue_ctrl_pkg::*;
#(
  parameter int RAM_PTR   = 10,
  parameter int HASH_BASE = 0,
  parameter int HAZ_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] req0_hash_e_f,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ELEM_W-1:0] req1_hash_e_f,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [ELEM_W-1:0] hash_e_f,
  output logic              valid,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [RAM_PTR-1:0] idx0;
  logic [RAM_PTR-1:0] idx1;
  logic [RAM_PTR-1:0] issue_idx;
  elem_t              issue_data;

  logic conf0, conf1, win_empty;
  logic run_en;
  logic elig0, elig1, contested;
  logic gnt0, gnt1, gnt_any;
  logic stall_evt;
  logic rr;  // 0: req0 wins the next contested cycle, 1: req1 wins

  drain_state_e state, state_next;

  assign idx0 = RAM_PTR'(bucket_idx(req0_hash_e_f, HASH_BASE));
  assign idx1 = RAM_PTR'(bucket_idx(req1_hash_e_f, HASH_BASE));

  bucket_haz_window #(
    .RAM_PTR   (RAM_PTR),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_haz_window (
    .clk         (clk),
    .rst         (rst),
    .in_v        (gnt_any),
    .in_idx      (issue_idx),
    .q0_idx      (idx0),
    .q1_idx      (idx1),
    .q0_conflict (conf0),
    .q1_conflict (conf1),
    .empty       (win_empty)
  );

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (drain_req) state_next = DRAIN;
      // Dropping drain_req wins over completion: the stage simply resumes.
      DRAIN:   if (!drain_req)             state_next = RUN;
               else if (!valid && win_empty) state_next = DONE;
      DONE:    if (!drain_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Admission is gated by rst as well so readies stay low while reset is
  // asserted, even before the first reset edge has settled the state.
  always_comb begin
    run_en     = (state == RUN) && !rst;
    drain_done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign elig0     = run_en && req0_valid && !conf0;
  assign elig1     = run_en && req1_valid && !conf1;
  assign contested = elig0 && elig1;

  // Two eligible requesters can share an index; granting only one of them
  // puts that index into the window, so the loser conflicts from next cycle.
  assign gnt0    = contested ? !rr : elig0;
  assign gnt1    = contested ?  rr : elig1;
  assign gnt_any = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    issue_data = '0;
    issue_idx  = '0;
    if (gnt0) begin
      issue_data = req0_hash_e_f;
      issue_idx  = idx0;
    end else if (gnt1) begin
      issue_data = req1_hash_e_f;
      issue_idx  = idx1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            rr <= 1'b0;
    else if (contested) rr <= ~rr;
  end

  // ---------------------------------------------------------------------------
  // Output register: one-cycle pulse per element, zero data on bubbles
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      hash_e_f <= '0;
    end else begin
      valid    <= gnt_any;
      hash_e_f <= issue_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  assign stall_evt = (req0_valid && !gnt0) || (req1_valid && !gnt1);

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_any && (issue_cnt != '1))   issue_cnt <= issue_cnt + 1'b1;
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bucket_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bucket_issue_ctrl
// Self-checking bench for bucket_issue_ctrl. A second instance with 4-bit
// counters shares all inputs to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_bucket_issue_ctrl;
  import bucket_issue_ctrl_pkg::*;

  localparam int RAM_PTR   = 10;
  localparam int HASH_BASE = 0;
  localparam int HAZ       = 4;
  localparam int CNT_W     = 32;
  localparam int SAT_W     = 4;
  localparam int NIDX      = 1 << RAM_PTR;

  typedef logic [171:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] req0_hash_e_f = '0;
  logic        req0_valid = 1'b0;
  logic [95:0] req1_hash_e_f = '0;
  logic        req1_valid = 1'b0;
  logic        drain_req = 1'b0;

  logic             req0_ready, req1_ready, valid, drain_done;
  logic [95:0]      hash_e_f;
  logic [CNT_W-1:0] issue_cnt, stall_cnt;

  logic             s_req0_ready, s_req1_ready, s_valid, s_drain_done;
  logic [95:0]      s_hash_e_f;
  logic [SAT_W-1:0] s_issue_cnt, s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state
  int     cyc = 0;
  int     last_issue [NIDX];
  int     last_any;
  bit     m_rr;
  int     mst;          // 0 running, 1 draining, 2 drained
  bit     m_valid;
  logic [95:0] m_data;
  longint m_issue, m_stall;
  bit     e_r0, e_r1;   // model grants of the last cycle
  bit     o_r0, o_r1;   // sampled DUT readies of the last cycle

  always #5 clk = ~clk;

  bucket_issue_ctrl #(
    .RAM_PTR(RAM_PTR), .HASH_BASE(HASH_BASE), .HAZ_DEPTH(HAZ), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_hash_e_f(req0_hash_e_f), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_hash_e_f(req1_hash_e_f), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .hash_e_f(hash_e_f), .valid(valid),
    .drain_req(drain_req), .drain_done(drain_done),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  bucket_issue_ctrl #(
    .RAM_PTR(RAM_PTR), .HASH_BASE(HASH_BASE), .HAZ_DEPTH(HAZ), .CNT_W(SAT_W)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .req0_hash_e_f(req0_hash_e_f), .req0_valid(req0_valid), .req0_ready(s_req0_ready),
    .req1_hash_e_f(req1_hash_e_f), .req1_valid(req1_valid), .req1_ready(s_req1_ready),
    .hash_e_f(s_hash_e_f), .valid(s_valid),
    .drain_req(drain_req), .drain_done(s_drain_done),
    .issue_cnt(s_issue_cnt), .stall_cnt(s_stall_cnt)
  );

  function automatic int idx_of(input logic [95:0] d);
    logic [31:0] h;
    h = d[95:64];
    return int'((h >> HASH_BASE) % (32'd1 << RAM_PTR));
  endfunction

  function automatic logic [95:0] make_elem(input int idx);
    logic [95:0] e;
    logic [31:0] iv;
    e  = {$urandom, $urandom, $urandom};
    iv = idx;
    e[64+HASH_BASE +: RAM_PTR] = iv[RAM_PTR-1:0];
    return e;
  endfunction

  function automatic logic [SAT_W-1:0] sat4(input longint v);
    longint c;
    c = (v > 15) ? 15 : v;
    return c[SAT_W-1:0];
  endfunction

  function automatic vec_t exp_vec();
    logic [31:0] ei, es;
    ei = m_issue[31:0];
    es = m_stall[31:0];
    return {e_r0, e_r1, m_valid, (mst == 2), m_data, ei, es, sat4(m_issue), sat4(m_stall)};
  endfunction

  function automatic vec_t obs_vec();
    return {o_r0, o_r1, valid, drain_done, hash_e_f, issue_cnt, stall_cnt,
            s_issue_cnt, s_stall_cnt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NIDX; i++) last_issue[i] = -1000;
    last_any = -1000;
    m_rr     = 1'b0;
    mst      = 0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_issue  = 0;
    m_stall  = 0;
  endtask

  // One clock cycle: sample readies mid-cycle, predict grants from the rules
  // (an index is blocked if it was issued within the last HAZ cycles), then
  // advance the model across the edge. Returns 1 time unit after the edge.
  task automatic cycle();
    bit el0, el1, empty_now;
    logic [95:0] d;
    el0 = 1'b0;
    el1 = 1'b0;
    @(negedge clk);
    o_r0 = req0_ready;
    o_r1 = req1_ready;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!rst) begin
      el0 = (mst == 0) && req0_valid && ((cyc - last_issue[idx_of(req0_hash_e_f)]) > HAZ);
      el1 = (mst == 0) && req1_valid && ((cyc - last_issue[idx_of(req1_hash_e_f)]) > HAZ);
      if (el0 && el1) begin
        e_r0 = !m_rr;
        e_r1 = m_rr;
      end else begin
        e_r0 = el0;
        e_r1 = el1;
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      empty_now = (cyc - last_any) > HAZ;
      if (el0 && el1) m_rr = !m_rr;
      if ((req0_valid && !e_r0) || (req1_valid && !e_r1)) m_stall++;
      if (e_r0 || e_r1) begin
        d = e_r0 ? req0_hash_e_f : req1_hash_e_f;
        m_issue++;
        last_issue[idx_of(d)] = cyc;
        last_any = cyc;
        m_valid  = 1'b1;
        m_data   = d;
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
      end
      case (mst)
        0: if (drain_req) mst = 1;
        1: if (!drain_req) mst = 0; else if (empty_now) mst = 2;
        default: if (!drain_req) mst = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain_req  = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_hash_e_f = make_elem(1);
    req1_valid = 1'b1; req1_hash_e_f = make_elem(2);
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      if ({o_r0, o_r1, valid, issue_cnt, stall_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_state got=%b%b%b %0d %0d exp=all zero",
                 o_r0, o_r1, valid, issue_cnt, stall_cnt);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (o_r0 !== 1'b1 || o_r1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant got=%b%b exp=10", o_r0, o_r1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single_port();
    logic [95:0] sent[$];
    logic [95:0] got[$];
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) begin
        req0_valid    = 1'b1;
        req0_hash_e_f = make_elem(k);
        sent.push_back(req0_hash_e_f);
      end else begin
        req0_valid = 1'b0;
      end
      cycle();
      if (valid) got.push_back(hash_e_f);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL single_pulses got=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== sent[i]) begin
          failures++;
          $display("FAIL single_order[%0d] got=%h exp=%h", i, got[i], sent[i]);
        end
      end
    end
    checks++;
    if (issue_cnt !== 32'd4) begin
      failures++;
      $display("FAIL single_issue_cnt got=%0d exp=4", issue_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] e2;
    int pulses[$];
    int sent;
    apply_reset();
    sent = 0;
    req0_valid    = 1'b1;
    req0_hash_e_f = make_elem(7);
    e2            = make_elem(7);
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (valid) pulses.push_back(n);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (o_r0) begin
        sent++;
        if (sent == 1) req0_hash_e_f = e2;
        else           req0_valid    = 1'b0;
      end
    end
    checks++;
    if (pulses.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", pulses.size());
    end else begin
      checks++;
      if (pulses[1] - pulses[0] != HAZ + 1) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", pulses[1] - pulses[0], HAZ + 1);
      end
    end
    checks++;
    if (stall_cnt !== 32'(HAZ)) begin
      failures++;
      $display("FAIL b2b_stall_cnt got=%0d exp=%0d", stall_cnt, HAZ);
    end
  endtask

  task automatic test_contention();
    int k0, k1, g0c, g1c;
    apply_reset();
    k0 = 0; k1 = 0;
    req0_valid = 1'b1; req0_hash_e_f = make_elem(10);
    req1_valid = 1'b1; req1_hash_e_f = make_elem(20);
    for (int n = 0; n < 8; n++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      if ({o_r0, o_r1} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_alternate n=%0d got=%b%b exp=%s", n, o_r0, o_r1,
                 (n % 2 == 0) ? "10" : "01");
      end
      if (o_r0) begin k0++; req0_hash_e_f = make_elem(10 + k0); end
      if (o_r1) begin k1++; req1_hash_e_f = make_elem(20 + k1); end
    end

    apply_reset();
    g0c = -1; g1c = -1;
    req0_valid = 1'b1; req0_hash_e_f = make_elem(5);
    req1_valid = 1'b1; req1_hash_e_f = make_elem(5);
    for (int n = 0; n < 12; n++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL same_idx_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (o_r0) begin g0c = n; req0_valid = 1'b0; end
      if (o_r1) begin g1c = n; req1_valid = 1'b0; end
    end
    checks++;
    if (g0c != 0 || g1c != HAZ + 1) begin
      failures++;
      $display("FAIL same_idx_grants got=%0d/%0d exp=0/%0d", g0c, g1c, HAZ + 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_drain();
    int n;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      req0_valid    = 1'b1;
      req0_hash_e_f = make_elem(30 + k);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL drain_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    req0_valid = 1'b0;
    drain_req  = 1'b1;
    cycle();
    n = 1;
    req0_valid    = 1'b1;
    req0_hash_e_f = make_elem(40);
    while (!drain_done && n < 3 * HAZ) begin
      cycle();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      if (o_r0 !== 1'b0) begin
        failures++;
        $display("FAIL drain_ready got=%b exp=0", o_r0);
      end
    end
    checks++;
    if (drain_done !== 1'b1 || n > HAZ + 1) begin
      failures++;
      $display("FAIL drain_done got=%b after %0d cycles exp=1 within %0d",
               drain_done, n, HAZ + 1);
    end
    drain_req = 1'b0;
    cycle();
    checks++;
    if (drain_done !== 1'b0 || o_r0 !== 1'b0) begin
      failures++;
      $display("FAIL drain_release got done=%b ready=%b exp=0/0", drain_done, o_r0);
    end
    cycle();
    checks++;
    if (o_r0 !== 1'b1 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL drain_resume got ready=%b exp=1 (vec %h vs %h)", o_r0, obs_vec(), exp_vec());
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      if (!req0_valid || o_r0) begin
        req0_valid    = ($urandom_range(0, 9) < 7);
        req0_hash_e_f = make_elem($urandom_range(0, 7));
      end
      if (!req1_valid || o_r1) begin
        req1_valid    = ($urandom_range(0, 9) < 6);
        req1_hash_e_f = make_elem($urandom_range(0, 7));
      end
      if ($urandom_range(0, 29) == 0) drain_req = !drain_req;
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    rst        = 1'b0;
    drain_req  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    drain_req     = 1'b1;
    req0_valid    = 1'b1;
    req0_hash_e_f = make_elem(3);
    for (int n = 0; n < 22; n++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL sat_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 32'd21) begin
      failures++;
      $display("FAIL sat_stall got=%0d/%0d exp=15/21", s_stall_cnt, stall_cnt);
    end
    drain_req  = 1'b0;
    req0_valid = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_port();
    test_back_to_back();
    test_contention();
    test_drain();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
